// File: rtl/booth_div_seq_pkg.sv
// Shared definitions for the sequential restoring divider: default width
// and the controller state encoding.
package booth_div_seq_pkg;

   // Default operand/result width, shared with the Booth multiplier.
   localparam int W_DEF = 8;

   // Controller states, 3-bit binary.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PREP = 3'd1,
      ITER = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_t;

endpackage

// File: rtl/booth_div_seq_div_abs_neg.sv
// Conditional two's-complement negation: y = cond ? -x : x.
// Serves as abs() on the operands and as sign fix-up on the results.
module div_abs_neg #(
   parameter int W = 8
) (
   input  logic [W-1:0] x,
   input  logic         cond,
   output logic [W-1:0] y
);

   assign y = cond ? -x : x;

endmodule

// File: rtl/booth_div_seq.sv
// Iterative radix-2 restoring divider, signed or unsigned.
// One operation in flight; results hold until the next completion.
module booth_div_seq
   import booth_div_seq_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         v_in,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sgn,
   output logic         rdy,
   output logic [W-1:0] q,
   output logic [W-1:0] r,
   output logic         dz,
   output logic         v_out
);

   localparam int CW = $clog2(W);

   state_t         state, state_nx;

   // Latched operands (a_l is also the remainder returned on divide-by-zero).
   logic [W-1:0]   a_l, b_l;
   logic           sgn_l;

   // Working registers: dvd shifts the dividend out and the quotient in.
   logic [W-1:0]   dvd;
   logic [W-1:0]   dvs;
   logic [W:0]     rem;
   logic [CW-1:0]  cnt;
   logic           neg_q, neg_r, zero_l;

   // Shared negation units: abs(a)/abs(b) in PREP, quotient/remainder fix in FIX.
   logic [W-1:0]   neg_x0, neg_y0, neg_x1, neg_y1;
   logic           neg_c0, neg_c1;

   // One iteration step: single subtractor, its borrow picks restore vs. keep.
   logic [W:0]     rem_sh;
   logic [W+1:0]   diff;
   logic           borrow;

   div_abs_neg #(.W(W)) u_neg0 (.x(neg_x0), .cond(neg_c0), .y(neg_y0));
   div_abs_neg #(.W(W)) u_neg1 (.x(neg_x1), .cond(neg_c1), .y(neg_y1));

   // Route the two negation units according to the current phase.
   always_comb begin
      if (state == PREP) begin
         neg_x0 = a_l;
         neg_c0 = sgn_l & a_l[W-1];
         neg_x1 = b_l;
         neg_c1 = sgn_l & b_l[W-1];
      end else begin
         neg_x0 = dvd;
         neg_c0 = neg_q;
         neg_x1 = rem[W-1:0];
         neg_c1 = neg_r;
      end
   end

   assign rem_sh = {rem[W-1:0], dvd[W-1]};
   assign diff   = {1'b0, rem_sh} - {2'b00, dvs};
   assign borrow = diff[W+1];

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state and ready decode.
   always_comb begin
      // NOTE: defaults first so no path through the case leaves a signal
      // unassigned and infers a latch.
      state_nx = state;
      rdy      = 1'b0;
      case (state)
         IDLE: begin
            rdy = 1'b1;
            if (v_in) state_nx = PREP;
         end
         PREP: state_nx = ITER;
         ITER: if (cnt == '0) state_nx = FIX;
         FIX:  state_nx = DONE;
         DONE: begin
            rdy      = 1'b1;
            state_nx = v_in ? PREP : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Datapath: operand capture, preparation, shift/subtract and sign fix-up.
   always_ff @(posedge clk) begin
      // NOTE: working registers carry no reset; every operation reloads them
      // in PREP before they are used, so only the visible outputs are reset.
      case (state)
         IDLE, DONE: begin
            if (v_in) begin
               a_l   <= a;
               b_l   <= b;
               sgn_l <= sgn;
            end
         end
         PREP: begin
            dvd    <= neg_y0;
            dvs    <= neg_y1;
            rem    <= '0;
            cnt    <= CW'(W - 1);
            neg_q  <= sgn_l & (a_l[W-1] ^ b_l[W-1]);
            neg_r  <= sgn_l & a_l[W-1];
            zero_l <= (b_l == '0);
         end
         ITER: begin
            rem <= borrow ? rem_sh : diff[W:0];
            dvd <= {dvd[W-2:0], ~borrow};
            cnt <= cnt - CW'(1);
         end
         FIX: begin
            dvd <= neg_y0;
            rem <= {1'b0, neg_y1};
         end
         default: ;
      endcase
   end

   // Result registers and completion pulse; outputs change only on completion or reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         q     <= '0;
         r     <= '0;
         dz    <= 1'b0;
         v_out <= 1'b0;
      end else begin
         v_out <= 1'b0;
         if (state == DONE) begin
            q     <= zero_l ? '1  : dvd;
            r     <= zero_l ? a_l : rem[W-1:0];
            dz    <= zero_l;
            v_out <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_booth_div_seq.sv
// Scoreboard bench for booth_div_seq: stimulus pushes expected results
// from an arithmetic reference model; a monitor pops on every v_out.
module tb_booth_div_seq;

   localparam int W   = 8;
   localparam int LAT = W + 3;

   logic         clk, rst, v_in, sgn;
   logic [W-1:0] a, b;
   logic         rdy, dz, v_out;
   logic [W-1:0] q, r;

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      int           acc;
      int           id;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   int   op_id = 0;

   booth_div_seq #(.W(W)) dut (
      .clk(clk), .rst(rst), .v_in(v_in), .a(a), .b(b), .sgn(sgn),
      .rdy(rdy), .q(q), .r(r), .dz(dz), .v_out(v_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Reference: plain integer division (truncating, remainder follows dividend).
   function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
      exp_t e;
      int   x, y, qi, ri;
      e = '0;
      if (bv == '0) begin
         e.q  = '1;
         e.r  = av;
         e.dz = 1'b1;
      end else begin
         if (sv) begin
            x = $signed(av);
            y = $signed(bv);
         end else begin
            x = av;
            y = bv;
         end
         qi   = x / y;
         ri   = x % y;
         e.q  = qi[W-1:0];
         e.r  = ri[W-1:0];
         e.dz = 1'b0;
      end
      return e;
   endfunction

   // Monitor: every completion pops one expectation and checks result and latency.
   always @(negedge clk) begin
      if (!rst && v_out === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_v_out: got v_out=1 at cycle %0d, required none pending", cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("q op%0d", e.id),  32'(q),  32'(e.q));
            check($sformatf("r op%0d", e.id),  32'(r),  32'(e.r));
            check($sformatf("dz op%0d", e.id), 32'(dz), 32'(e.dz));
            check($sformatf("latency op%0d", e.id), 32'(cyc - e.acc), 32'(LAT));
         end
      end
   end

   // Present one operation at a negedge once rdy is seen; track=0 issues without expectation.
   task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts, input bit track);
      int   waited = 0;
      exp_t e;
      while (rdy !== 1'b1 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (rdy !== 1'b1) begin
         n_cmp++;
         n_bad++;
         $display("FAIL rdy_timeout: got rdy=%b after %0d cycles, required 1", rdy, waited);
         return;
      end
      a    = ta;
      b    = tb;
      sgn  = ts;
      v_in = 1'b1;
      if (track) begin
         e     = model(ta, tb, ts);
         e.acc = cyc + 1;
         e.id  = op_id++;
         exp_q.push_back(e);
      end
      @(negedge clk);
      v_in = 1'b0;
   endtask

   task automatic drain();
      int waited = 0;
      while (exp_q.size() != 0 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d results outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no end of test, required completion");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] ra, rb;
      exp_t         e;
      rst  = 1'b1;
      v_in = 1'b0;
      a    = '0;
      b    = '0;
      sgn  = 1'b0;
      repeat (3) @(negedge clk);
      check("reset rdy",   32'(rdy),   32'd1);
      check("reset v_out", 32'(v_out), 32'd0);
      check("reset q",     32'(q),     32'd0);
      check("reset r",     32'(r),     32'd0);
      check("reset dz",    32'(dz),    32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed cases, issued back to back.
      issue(8'd100, 8'd7,    1'b0, 1);
      issue(8'h9C,  8'h07,   1'b1, 1);
      issue(8'd100, 8'hF9,   1'b1, 1);
      issue(8'h37,  8'h00,   1'b0, 1);
      issue(8'd9,   8'd3,    1'b0, 1);
      issue(8'h37,  8'h00,   1'b1, 1);
      issue(8'd9,   8'd3,    1'b1, 1);
      issue(8'h80,  8'hFF,   1'b1, 1);
      issue(8'hFF,  8'h01,   1'b0, 1);
      drain();

      // Results hold after completion.
      repeat (5) @(negedge clk);
      check("hold q", 32'(q), 32'hFF);
      check("hold r", 32'(r), 32'h00);

      // v_in held high with fresh operands every cycle: only every LAT-th is accepted.
      for (int i = 0; i < 3 * LAT; i++) begin
         ra   = W'($urandom);
         rb   = W'($urandom_range(1, 255));
         a    = ra;
         b    = rb;
         sgn  = 1'($urandom);
         v_in = 1'b1;
         check($sformatf("rdy stream %0d", i), 32'(rdy), 32'((i % LAT) == 0));
         if ((i % LAT) == 0) begin
            e     = model(ra, rb, sgn);
            e.acc = cyc + 1;
            e.id  = op_id++;
            exp_q.push_back(e);
         end
         @(negedge clk);
      end
      v_in = 1'b0;
      drain();

      // Reset in the middle of an iteration discards the operation.
      issue(8'h55, 8'h03, 1'b0, 0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst rdy",   32'(rdy),   32'd1);
      check("midrst q",     32'(q),     32'd0);
      check("midrst r",     32'(r),     32'd0);
      check("midrst dz",    32'(dz),    32'd0);
      check("midrst v_out", 32'(v_out), 32'd0);
      rst = 1'b0;
      repeat (15) @(negedge clk);
      issue(8'h55, 8'h03, 1'b0, 1);
      drain();

      // Random operations in both modes with occasional corner operands.
      for (int i = 0; i < 2000; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         case ($urandom_range(0, 15))
            0: rb = '0;
            1: begin ra = 8'h80; rb = 8'hFF; end
            2: rb = 8'h01;
            default: ;
         endcase
         if (rb == '0 && $urandom_range(0, 3) != 0) rb = 8'h01;
         issue(ra, rb, 1'($urandom), 1);
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
